// File: rtl/msoc_mem_copy_master_if.sv
// Avalon-MM master bus used by the memory copy engine: word-wide reads and
// writes with waitrequest stalls and pipelined read return.
interface msoc_mem_copy_master_if #(
   parameter int ADDR_W = 32
) ();

   logic [ADDR_W-1:0] m_address;
   logic              m_read;
   logic              m_write;
   logic [31:0]       m_writedata;
   logic [3:0]        m_byteenable;
   logic              m_waitrequest;
   logic [31:0]       m_readdata;
   logic              m_readdatavalid;

   // Initiator side (the copy engine).
   modport master (
      output m_address,
      output m_read,
      output m_write,
      output m_writedata,
      output m_byteenable,
      input  m_waitrequest,
      input  m_readdata,
      input  m_readdatavalid
   );

   // Memory side (RAM slave or bench model).
   modport slave (
      input  m_address,
      input  m_read,
      input  m_write,
      input  m_writedata,
      input  m_byteenable,
      output m_waitrequest,
      output m_readdata,
      output m_readdatavalid
   );

endinterface

// File: rtl/msoc_mem_copy_master.sv
// Memory-to-memory word copy engine. A CPU programs SRC/DST/LEN through a
// zero-wait control slave and starts it with CTRL.go; the engine then reads
// one word, buffers it, and writes it out, one word at a time (at most one
// read outstanding). Completion sets a sticky STATUS.done and, if enabled,
// raises irq.
module msoc_mem_copy_master #(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [2:0]              ctl_address,
   input  logic                    ctl_chipselect,
   input  logic                    ctl_write,
   input  logic [31:0]             ctl_writedata,
   output logic [31:0]             ctl_readdata,
   output logic                    irq,
   msoc_mem_copy_master_if.master  m
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RD_REQ  = 2'd1;
   localparam logic [1:0] S_RD_WAIT = 2'd2;
   localparam logic [1:0] S_WR_REQ  = 2'd3;

   localparam logic [2:0] REG_SRC    = 3'd0;
   localparam logic [2:0] REG_DST    = 3'd1;
   localparam logic [2:0] REG_LEN    = 3'd2;
   localparam logic [2:0] REG_CTRL   = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;

   logic [1:0]        state_q,   state_d;
   logic [ADDR_W-1:0] src_q,     src_d;
   logic [ADDR_W-1:0] dst_q,     dst_d;
   logic [LEN_W-1:0]  len_q,     len_d;
   logic              ie_q,      ie_d;
   logic              done_q,    done_d;
   logic [ADDR_W-1:0] cur_src_q, cur_src_d;
   logic [ADDR_W-1:0] cur_dst_q, cur_dst_d;
   logic [31:0]       buf_q,     buf_d;

   logic busy;
   logic ctl_wr;
   logic go;

   assign busy   = (state_q != S_IDLE);
   assign ctl_wr = ctl_chipselect & ctl_write;

   // Register writes and copy sequencing. The done-clear from a STATUS write
   // is applied before the FSM so a same-cycle completion overrides it.
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      len_d     = len_q;
      ie_d      = ie_q;
      done_d    = done_q;
      cur_src_d = cur_src_q;
      cur_dst_d = cur_dst_q;
      buf_d     = buf_q;
      go        = 1'b0;

      if (ctl_wr) begin
         case (ctl_address)
            REG_SRC: begin
               if (!busy) src_d = {ctl_writedata[ADDR_W-1:2], 2'b00};
            end
            REG_DST: begin
               if (!busy) dst_d = {ctl_writedata[ADDR_W-1:2], 2'b00};
            end
            REG_LEN: begin
               if (!busy) len_d = ctl_writedata[LEN_W-1:0];
            end
            REG_CTRL: begin
               ie_d = ctl_writedata[1];
               go   = ctl_writedata[0] & ~busy;
            end
            REG_STATUS: begin
               if (ctl_writedata[1]) done_d = 1'b0;
            end
            default: ;
         endcase
      end

      case (state_q)
         S_IDLE: begin
            if (go) begin
               if (len_q != '0) begin
                  state_d   = S_RD_REQ;
                  done_d    = 1'b0;
                  cur_src_d = src_q;
                  cur_dst_d = dst_q;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_RD_REQ: begin
            if (!m.m_waitrequest) state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (m.m_readdatavalid) begin
               buf_d   = m.m_readdata;
               state_d = S_WR_REQ;
            end
         end
         S_WR_REQ: begin
            if (!m.m_waitrequest) begin
               len_d     = len_q - LEN_W'(1);
               cur_src_d = cur_src_q + ADDR_W'(4);
               cur_dst_d = cur_dst_q + ADDR_W'(4);
               if (len_q == LEN_W'(1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_RD_REQ;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and register flops with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= '0;
         ie_q      <= 1'b0;
         done_q    <= 1'b0;
         cur_src_q <= '0;
         cur_dst_q <= '0;
         buf_q     <= '0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         len_q     <= len_d;
         ie_q      <= ie_d;
         done_q    <= done_d;
         cur_src_q <= cur_src_d;
         cur_dst_q <= cur_dst_d;
         buf_q     <= buf_d;
      end
   end

   // Bus outputs decoded from state so they hold steady through stalls.
   always_comb begin
      m.m_read       = (state_q == S_RD_REQ);
      m.m_write      = (state_q == S_WR_REQ);
      m.m_byteenable = 4'hF;
      m.m_address    = '0;
      m.m_writedata  = '0;
      if (state_q == S_RD_REQ) m.m_address = cur_src_q;
      if (state_q == S_WR_REQ) begin
         m.m_address   = cur_dst_q;
         m.m_writedata = buf_q;
      end
   end

   // Zero-latency control read mux; narrower registers are zero-extended.
   always_comb begin
      logic [31:0] src_ext;
      logic [31:0] dst_ext;
      logic [31:0] len_ext;
      src_ext = '0;
      dst_ext = '0;
      len_ext = '0;
      src_ext[ADDR_W-1:0] = src_q;
      dst_ext[ADDR_W-1:0] = dst_q;
      len_ext[LEN_W-1:0]  = len_q;
      case (ctl_address)
         REG_SRC:    ctl_readdata = src_ext;
         REG_DST:    ctl_readdata = dst_ext;
         REG_LEN:    ctl_readdata = len_ext;
         REG_CTRL:   ctl_readdata = {30'd0, ie_q, 1'b0};
         REG_STATUS: ctl_readdata = {30'd0, done_q, busy};
         default:    ctl_readdata = '0;
      endcase
   end

   assign irq = done_q & ie_q;

endmodule

// File: tb/tb_msoc_mem_copy_master.sv
// Directed bench for the memory copy engine with a word RAM slave model that
// can insert 3-cycle waitrequest stalls on every transfer.
module tb_msoc_mem_copy_master;

   localparam int ADDR_W = 32;
   localparam int LEN_W  = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  ctl_address = '0;
   logic        ctl_chipselect = 1'b0;
   logic        ctl_write = 1'b0;
   logic [31:0] ctl_writedata = '0;
   logic [31:0] ctl_readdata;
   logic        irq;

   msoc_mem_copy_master_if #(.ADDR_W(ADDR_W)) bus ();

   msoc_mem_copy_master #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .ctl_address   (ctl_address),
      .ctl_chipselect(ctl_chipselect),
      .ctl_write     (ctl_write),
      .ctl_writedata (ctl_writedata),
      .ctl_readdata  (ctl_readdata),
      .irq           (irq),
      .m             (bus.master)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] mem [0:16383];
   bit          stall_en = 1'b0;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return 32'hC0DE_0000 ^ (a * 32'h0000_9E37);
   endfunction

   // RAM slave: decides waitrequest at each falling edge, acts on the
   // transfer accepted at the following rising edge, returns read data one
   // cycle after acceptance.
   initial begin
      int          stall_cnt;
      bit          rd_pend;
      logic [31:0] rd_addr;
      for (int i = 0; i < 16384; i++) mem[i] = pat(32'(i) << 2);
      bus.m_waitrequest   = 1'b0;
      bus.m_readdatavalid = 1'b0;
      bus.m_readdata      = '0;
      stall_cnt = 0;
      rd_pend   = 1'b0;
      rd_addr   = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            bus.m_waitrequest   = 1'b0;
            bus.m_readdatavalid = 1'b0;
            bus.m_readdata      = '0;
            stall_cnt = 0;
            rd_pend   = 1'b0;
         end else begin
            bus.m_readdatavalid = rd_pend;
            bus.m_readdata      = rd_pend ? mem[rd_addr[15:2]] : 32'h0;
            rd_pend = 1'b0;
            if (bus.m_read === 1'b1 || bus.m_write === 1'b1) begin
               if (stall_en && stall_cnt < 3) begin
                  bus.m_waitrequest = 1'b1;
                  stall_cnt++;
               end else begin
                  bus.m_waitrequest = 1'b0;
                  stall_cnt = 0;
                  if (bus.m_read === 1'b1) begin
                     rd_pend = 1'b1;
                     rd_addr = bus.m_address;
                  end else begin
                     mem[bus.m_address[15:2]] = bus.m_writedata;
                  end
               end
            end else begin
               bus.m_waitrequest = 1'b0;
               stall_cnt = 0;
            end
         end
      end
   end

   task automatic ctl_wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      ctl_chipselect = 1'b1;
      ctl_write      = 1'b1;
      ctl_address    = a;
      ctl_writedata  = d;
      @(negedge clk);
      ctl_chipselect = 1'b0;
      ctl_write      = 1'b0;
      ctl_writedata  = '0;
   endtask

   task automatic ctl_rd(input logic [2:0] a, output logic [31:0] d);
      ctl_address = a;
      #1;
      d = ctl_readdata;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      ctl_address = 3'd4;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         #1;
         if (ctl_readdata[0] === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if ({bus.m_read, bus.m_write, irq} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_strobes: got rd/wr/irq=%b want 000", {bus.m_read, bus.m_write, irq});
      end
      n_cmp++;
      if (bus.m_address !== 32'h0 || bus.m_writedata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_bus: got addr=%h wdata=%h want 0/0", bus.m_address, bus.m_writedata);
      end
      n_cmp++;
      if (bus.m_byteenable !== 4'hF) begin
         n_fail++;
         $display("FAIL byteenable: got %h want f", bus.m_byteenable);
      end
      for (int i = 0; i < 8; i++) begin
         ctl_rd(3'(i), d);
         n_cmp++;
         if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_reg%0d: got %h want 0", i, d);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      ctl_wr(3'd6, 32'hFFFF_FFFF);
      ctl_rd(3'd6, d);
      n_cmp++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL unused_reg: got %h want 0", d);
      end
   endtask

   task automatic test_basic_copy();
      logic [31:0] d;
      int rd_n, wr_n, both_n;
      rd_n = 0; wr_n = 0; both_n = 0;
      ctl_wr(3'd0, 32'h0);
      ctl_wr(3'd1, 32'h100);
      ctl_wr(3'd2, 32'd4);
      ctl_wr(3'd3, 32'h3);
      ctl_address = 3'd4;
      for (int k = 0; k <= 12; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         if (k == 0) begin
            n_cmp++;
            if (bus.m_read !== 1'b1) begin
               n_fail++;
               $display("FAIL read_after_go: got m_read=%b want 1", bus.m_read);
            end
         end
         if (bus.m_read === 1'b1 && bus.m_write === 1'b1) both_n++;
         if (bus.m_read === 1'b1 && bus.m_waitrequest === 1'b0) rd_n++;
         if (bus.m_write === 1'b1 && bus.m_waitrequest === 1'b0) wr_n++;
         if (k == 11) begin
            n_cmp++;
            if (ctl_readdata[1] !== 1'b0) begin
               n_fail++;
               $display("FAIL done_early: got done=%b at cycle 11 want 0", ctl_readdata[1]);
            end
         end
         if (k == 12) begin
            n_cmp++;
            if (ctl_readdata !== 32'h2 || irq !== 1'b1) begin
               n_fail++;
               $display("FAIL done_at_12: got status=%h irq=%b want 2/1", ctl_readdata, irq);
            end
         end
      end
      n_cmp++;
      if (rd_n != 4 || wr_n != 4 || both_n != 0) begin
         n_fail++;
         $display("FAIL basic_counts: got rd=%0d wr=%0d both=%0d want 4/4/0", rd_n, wr_n, both_n);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (mem[64 + i] !== pat(32'(i * 4))) begin
            n_fail++;
            $display("FAIL basic_data%0d: got %h want %h", i, mem[64 + i], pat(32'(i * 4)));
         end
      end
      ctl_rd(3'd2, d);
      n_cmp++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL basic_len: got %h want 0", d);
      end
      ctl_rd(3'd3, d);
      n_cmp++;
      if (d !== 32'h2) begin
         n_fail++;
         $display("FAIL ctrl_read: got %h want 2", d);
      end
   endtask

   task automatic test_done_clear();
      logic [31:0] d;
      ctl_wr(3'd4, 32'h2);
      ctl_rd(3'd4, d);
      n_cmp++;
      if (d !== 32'h0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL done_clear: got status=%h irq=%b want 0/0", d, irq);
      end
   endtask

   task automatic test_len_zero();
      logic [31:0] d;
      int strobe_n;
      strobe_n = 0;
      ctl_wr(3'd2, 32'h0);
      ctl_wr(3'd3, 32'h3);
      ctl_rd(3'd4, d);
      n_cmp++;
      if (d !== 32'h2 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL len0_done: got status=%h irq=%b want 2/1", d, irq);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         if (bus.m_read !== 1'b0 || bus.m_write !== 1'b0) strobe_n++;
      end
      n_cmp++;
      if (strobe_n != 0) begin
         n_fail++;
         $display("FAIL len0_traffic: got %0d strobe cycles want 0", strobe_n);
      end
      ctl_wr(3'd4, 32'h2);
   endtask

   task automatic test_done_set_wins();
      logic [31:0] d;
      ctl_wr(3'd0, 32'h300);
      ctl_wr(3'd1, 32'h380);
      ctl_wr(3'd2, 32'd1);
      ctl_wr(3'd3, 32'h1);
      @(negedge clk);
      ctl_wr(3'd4, 32'h2);
      ctl_rd(3'd4, d);
      n_cmp++;
      if (d !== 32'h2) begin
         n_fail++;
         $display("FAIL set_wins: got status=%h want 2", d);
      end
      n_cmp++;
      if (mem[32'h380 >> 2] !== pat(32'h300)) begin
         n_fail++;
         $display("FAIL set_wins_data: got %h want %h", mem[32'h380 >> 2], pat(32'h300));
      end
      ctl_wr(3'd4, 32'h2);
   endtask

   task automatic test_stall();
      logic [31:0] snap_addr, snap_wd;
      logic [1:0]  snap_rw;
      bit          prev_stall, finished;
      int rd_n, wr_n, both_n, stall_n, unstable_n;
      rd_n = 0; wr_n = 0; both_n = 0; stall_n = 0; unstable_n = 0;
      prev_stall = 1'b0; finished = 1'b0;
      snap_addr = '0; snap_wd = '0; snap_rw = '0;
      stall_en = 1'b1;
      ctl_wr(3'd0, 32'h200);
      ctl_wr(3'd1, 32'h400);
      ctl_wr(3'd2, 32'd8);
      ctl_wr(3'd3, 32'h3);
      ctl_address = 3'd4;
      for (int k = 0; k < 400; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         if (prev_stall) begin
            n_cmp++;
            if ({bus.m_read, bus.m_write} !== snap_rw || bus.m_address !== snap_addr ||
                bus.m_writedata !== snap_wd) begin
               n_fail++;
               unstable_n++;
               $display("FAIL stall_hold: got rw=%b addr=%h wd=%h want rw=%b addr=%h wd=%h",
                        {bus.m_read, bus.m_write}, bus.m_address, bus.m_writedata,
                        snap_rw, snap_addr, snap_wd);
            end
         end
         if (bus.m_read === 1'b1 && bus.m_write === 1'b1) both_n++;
         prev_stall = (bus.m_read === 1'b1 || bus.m_write === 1'b1) && bus.m_waitrequest === 1'b1;
         if (prev_stall) stall_n++;
         snap_rw   = {bus.m_read, bus.m_write};
         snap_addr = bus.m_address;
         snap_wd   = bus.m_writedata;
         if (bus.m_read === 1'b1 && bus.m_waitrequest === 1'b0) rd_n++;
         if (bus.m_write === 1'b1 && bus.m_waitrequest === 1'b0) wr_n++;
         if (k > 0 && ctl_readdata[0] === 1'b0) begin
            finished = 1'b1;
            break;
         end
      end
      stall_en = 1'b0;
      n_cmp++;
      if (!finished || ctl_readdata !== 32'h2 || irq !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_finish: got finished=%0d status=%h irq=%b want 1/2/1",
                  finished, ctl_readdata, irq);
      end
      n_cmp++;
      if (rd_n != 8 || wr_n != 8 || both_n != 0 || stall_n != 48) begin
         n_fail++;
         $display("FAIL stall_counts: got rd=%0d wr=%0d both=%0d stalls=%0d want 8/8/0/48",
                  rd_n, wr_n, both_n, stall_n);
      end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (mem[256 + i] !== pat(32'h200 + 32'(i * 4))) begin
            n_fail++;
            $display("FAIL stall_data%0d: got %h want %h", i, mem[256 + i], pat(32'h200 + 32'(i * 4)));
         end
      end
      ctl_wr(3'd4, 32'h2);
   endtask

   task automatic test_busy_ignore();
      logic [31:0] d;
      bit ok;
      stall_en = 1'b1;
      ctl_wr(3'd0, 32'h600);
      ctl_wr(3'd1, 32'h800);
      ctl_wr(3'd2, 32'd4);
      ctl_wr(3'd3, 32'h3);
      ctl_wr(3'd0, 32'hFFF0);
      ctl_wr(3'd1, 32'h1000);
      ctl_wr(3'd2, 32'h50);
      ctl_wr(3'd3, 32'h3);
      wait_idle(400, ok);
      stall_en = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL busy_timeout: got busy after 400 cycles want idle");
      end
      repeat (3) @(negedge clk);
      ctl_rd(3'd4, d);
      n_cmp++;
      if (d !== 32'h2) begin
         n_fail++;
         $display("FAIL busy_restart: got status=%h want 2", d);
      end
      ctl_rd(3'd0, d);
      n_cmp++;
      if (d !== 32'h600) begin
         n_fail++;
         $display("FAIL busy_src: got %h want 600", d);
      end
      ctl_rd(3'd1, d);
      n_cmp++;
      if (d !== 32'h800) begin
         n_fail++;
         $display("FAIL busy_dst: got %h want 800", d);
      end
      ctl_rd(3'd2, d);
      n_cmp++;
      if (d !== 32'h0) begin
         n_fail++;
         $display("FAIL busy_len: got %h want 0", d);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (mem[512 + i] !== pat(32'h600 + 32'(i * 4))) begin
            n_fail++;
            $display("FAIL busy_data%0d: got %h want %h", i, mem[512 + i], pat(32'h600 + 32'(i * 4)));
         end
      end
      n_cmp++;
      if (mem[32'h1000 >> 2] !== pat(32'h1000)) begin
         n_fail++;
         $display("FAIL busy_stray: got %h want %h", mem[32'h1000 >> 2], pat(32'h1000));
      end
      ctl_wr(3'd4, 32'h2);
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      bit found;
      found = 1'b0;
      ctl_wr(3'd0, 32'h0);
      ctl_wr(3'd1, 32'hA00);
      ctl_wr(3'd2, 32'd4);
      ctl_wr(3'd3, 32'h3);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         #1;
         if (bus.m_write === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!found) begin
         n_fail++;
         $display("FAIL mid_no_write: got no write in 20 cycles want one");
      end
      reset = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.m_write !== 1'b0 || bus.m_read !== 1'b0 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_strobes: got wr=%b rd=%b irq=%b want 0/0/0", bus.m_write, bus.m_read, irq);
      end
      for (int i = 0; i < 5; i++) begin
         ctl_rd(3'(i), d);
         n_cmp++;
         if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reg%0d: got %h want 0", i, d);
         end
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic_copy();
      test_done_clear();
      test_len_zero();
      test_done_set_wins();
      test_stall();
      test_busy_ignore();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
